// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter for the IF and DS requesters: data priority with a fetch starvation guard.
// Optional stall counter port enabled by defining ARB_STALL_CNT_EN.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        ds_req,
    input  logic        ds_we,
    output logic        ds_gnt,
    output logic        ds_rvalid,
    output logic        mem_sel,
    output logic        mem_en,
    output logic        mem_we
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] lat_q, lat_d;
    logic [3:0] starve_q, starve_d;
    logic       owner_q, owner_d;
    logic       we_q, we_d;
    logic       first_q, first_d;
    logic       if_rv_q, if_rv_d;
    logic       ds_rv_q, ds_rv_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        owner_d  = owner_q;
        we_d     = we_q;
        first_d  = 1'b0;
        if_rv_d  = 1'b0;
        ds_rv_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || ds_req) begin
                    state_d = BUSY;
                    lat_d   = LAT;
                    first_d = 1'b1;
                    // IF wins when alone or once DS has beaten it STARVE_LIMIT times in a row
                    if (if_req && (!ds_req || starve_q >= LIM)) begin
                        owner_d  = 1'b0;
                        we_d     = 1'b0;
                        starve_d = 4'd0;
                    end else begin
                        owner_d = 1'b1;
                        we_d    = ds_we;
                        if (if_req) starve_d = starve_q + 4'd1;
                    end
                end
            end
            BUSY: begin
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) begin
                    state_d = IDLE;
                    if_rv_d = ~owner_q;
                    ds_rv_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lat_q    <= 4'd0;
            starve_q <= 4'd0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            first_q  <= 1'b0;
            if_rv_q  <= 1'b0;
            ds_rv_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            first_q  <= first_d;
            if_rv_q  <= if_rv_d;
            ds_rv_q  <= ds_rv_d;
        end
    end

    assign if_gnt    = first_q & ~owner_q;
    assign ds_gnt    = first_q & owner_q;
    assign mem_en    = first_q;
    assign mem_we    = first_q & owner_q & we_q;
    assign mem_sel   = owner_q;
    assign if_rvalid = if_rv_q;
    assign ds_rvalid = ds_rv_q;

`ifdef ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 32'd0;
        else if ((if_req & ~if_gnt) | (ds_req & ~ds_gnt))
            stall_cnt <= sat_inc(stall_cnt);
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: event-schedule reference model plus directed literal checks.
module tb_mem_port_arbiter;
    localparam int L  = 2;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic if_req = 1'b0, ds_req = 1'b0, ds_we = 1'b0;
    logic if_gnt, if_rvalid, ds_gnt, ds_rvalid, mem_sel, mem_en, mem_we;
`ifdef ARB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .ds_req(ds_req), .ds_we(ds_we), .ds_gnt(ds_gnt), .ds_rvalid(ds_rvalid),
        .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we)
`ifdef ARB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: each access is a schedule of absolute cycle numbers (grant, rvalid, next free sample)
    int          cyc      = 0;
    int          gnt_cyc  = -1;
    int          rv_cyc   = -1;
    int          free_at  = 0;
    bit          m_own    = 1'b0;
    bit          m_we     = 1'b0;
    int          m_starve = 0;
    logic [31:0] m_stall  = 32'd0;

    function automatic bit e_gnt(input bit who);
        return (cyc == gnt_cyc) && (m_own == who);
    endfunction

    function automatic bit e_rv(input bit who);
        return (cyc == rv_cyc) && (m_own == who);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            gnt_cyc = -1; rv_cyc = -1; free_at = 0;
            m_own = 1'b0; m_we = 1'b0; m_starve = 0; m_stall = 32'd0;
        end else begin
            if ((if_req && !e_gnt(1'b0)) || (ds_req && !e_gnt(1'b1)))
                if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (cyc >= free_at && (if_req || ds_req)) begin
                if (if_req && (!ds_req || m_starve == SL)) begin
                    m_own = 1'b0; m_we = 1'b0; m_starve = 0;
                end else begin
                    m_own = 1'b1; m_we = ds_we;
                    if (if_req) m_starve = m_starve + 1;
                end
                gnt_cyc = cyc + 1;
                rv_cyc  = cyc + 1 + L;
                free_at = cyc + 1 + L;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                check("rst_if_gnt", 32'(if_gnt), 32'd0);
                check("rst_ds_gnt", 32'(ds_gnt), 32'd0);
                check("rst_mem_en", 32'(mem_en), 32'd0);
                check("rst_mem_sel", 32'(mem_sel), 32'd0);
                check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
                check("rst_ds_rvalid", 32'(ds_rvalid), 32'd0);
            end else begin
                check("if_gnt", 32'(if_gnt), 32'(e_gnt(1'b0)));
                check("ds_gnt", 32'(ds_gnt), 32'(e_gnt(1'b1)));
                check("mem_en", 32'(mem_en), 32'(cyc == gnt_cyc));
                check("mem_we", 32'(mem_we), 32'((cyc == gnt_cyc) && m_own && m_we));
                check("mem_sel", 32'(mem_sel), 32'(m_own));
                check("if_rvalid", 32'(if_rvalid), 32'(e_rv(1'b0)));
                check("ds_rvalid", 32'(ds_rvalid), 32'(e_rv(1'b1)));
`ifdef ARB_STALL_CNT_EN
                check("stall_cnt", stall_cnt, m_stall);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        string ord;
        int    got;
        // Reset takes effect without a clock edge
        #1 rst = 1'b1;
        #1;
        check("reset_async_if_gnt", 32'(if_gnt), 32'd0);
        check("reset_async_mem_en", 32'(mem_en), 32'd0);
        check("reset_async_mem_sel", 32'(mem_sel), 32'd0);
        check("reset_async_ds_rvalid", 32'(ds_rvalid), 32'd0);
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (3) tick();
        check("idle_no_req_mem_en", 32'(mem_en), 32'd0);
        check("idle_no_req_mem_sel", 32'(mem_sel), 32'd0);

        // Single fetch with req held into a second access
        if_req = 1'b1;
        tick();
        check("fetch_c1_if_gnt", 32'(if_gnt), 32'd1);
        check("fetch_c1_mem_en", 32'(mem_en), 32'd1);
        check("fetch_c1_mem_sel", 32'(mem_sel), 32'd0);
        check("fetch_c1_mem_we", 32'(mem_we), 32'd0);
        tick();
        check("fetch_c2_if_gnt", 32'(if_gnt), 32'd0);
        tick();
        check("fetch_c3_if_rvalid", 32'(if_rvalid), 32'd1);
        tick();
        check("fetch_c4_if_gnt", 32'(if_gnt), 32'd1);
        if_req = 1'b0;
        repeat (4) tick();

        // Store
        ds_req = 1'b1; ds_we = 1'b1;
        tick();
        check("store_ds_gnt", 32'(ds_gnt), 32'd1);
        check("store_mem_sel", 32'(mem_sel), 32'd1);
        check("store_mem_en", 32'(mem_en), 32'd1);
        check("store_mem_we", 32'(mem_we), 32'd1);
        ds_req = 1'b0; ds_we = 1'b0;
        tick();
        check("store_after_mem_we", 32'(mem_we), 32'd0);
        tick();
        check("store_ds_rvalid", 32'(ds_rvalid), 32'd1);
        repeat (4) tick();

        // Contention
        if_req = 1'b1; ds_req = 1'b1;
        ord = "";
        got = 0;
        for (int i = 0; i < 80 && got < 10; i++) begin
            tick();
            if (if_gnt) begin ord = {ord, "I"}; got++; end
            else if (ds_gnt) begin ord = {ord, "D"}; got++; end
        end
        n_tot++;
        if (ord == "DDDDIDDDDI") n_pass++;
        else $display("FAIL grant_order: got %s expected DDDDIDDDDI", ord);
        if_req = 1'b0; ds_req = 1'b0;
        repeat (5) tick();

        // Reset in the cycle after a grant drops the access
        ds_req = 1'b1; ds_we = 1'b0;
        tick();
        check("rstmid_ds_gnt", 32'(ds_gnt), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_mem_sel", 32'(mem_sel), 32'd0);
        check("rstmid_ds_rvalid", 32'(ds_rvalid), 32'd0);
        tick();
        check("rstmid_held_ds_rvalid", 32'(ds_rvalid), 32'd0);
        rst = 1'b0;
        tick();
        check("rstmid_second_edge_ds_gnt", 32'(ds_gnt), 32'd1);
        ds_req = 1'b0;
        repeat (5) tick();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            tick();
            if_req = ($urandom_range(0, 3) != 0);
            ds_req = ($urandom_range(0, 2) != 0);
            ds_we  = $urandom_range(0, 1) == 1;
            rst    = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0; if_req = 1'b0; ds_req = 1'b0; ds_we = 1'b0;
        repeat (5) tick();

`ifdef ARB_STALL_CNT_EN
        rst = 1'b1; if_req = 1'b1; ds_req = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("stall_cnt_20", stall_cnt, 32'd20);
        if_req = 1'b0; ds_req = 1'b0;
        repeat (5) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
